// File: rtl/box_bouncer_if.sv
// Control and adapter-side signals of box_bouncer.
// The master modport is the animator's view; slave is the board/adapter side.
interface box_bouncer_if #(
  parameter int unsigned X_W = 8,
  parameter int unsigned Y_W = 7
) ();
  logic           run;
  logic           pause;
  logic [2:0]     colour_in;
  logic [2:0]     speed_x;
  logic [2:0]     speed_y;
  logic           load;
  logic [X_W-1:0] load_x;
  logic [Y_W-1:0] load_y;
  logic [X_W-1:0] x_out;
  logic [Y_W-1:0] y_out;
  logic [2:0]     colour_out;
  logic           plot;
  logic           busy;
  logic           dir_right;
  logic           dir_down;
  logic           bounce_x;
  logic           bounce_y;

  modport master (
    input  run, pause, colour_in, speed_x, speed_y, load, load_x, load_y,
    output x_out, y_out, colour_out, plot, busy, dir_right, dir_down, bounce_x, bounce_y
  );

  modport slave (
    output run, pause, colour_in, speed_x, speed_y, load, load_x, load_y,
    input  x_out, y_out, colour_out, plot, busy, dir_right, dir_down, bounce_x, bounce_y
  );
endinterface

// File: rtl/box_bouncer.sv
// Bouncing-rectangle animator: draw, wait a number of frame ticks, erase, move.
// Pixel outputs are registered and feed the VGA adapter's write port directly.
module box_bouncer #(
  parameter int unsigned SCR_W           = 160,
  parameter int unsigned SCR_H           = 120,
  parameter int unsigned BOX_W           = 4,
  parameter int unsigned BOX_H           = 4,
  parameter int unsigned X_W             = 8,
  parameter int unsigned Y_W             = 7,
  parameter int unsigned FRAME_TICKS     = 833333,
  parameter int unsigned FRAMES_PER_STEP = 15
) (
  input logic           clk,
  input logic           reset,
  box_bouncer_if.master bus
);
  localparam int unsigned CW = $clog2(BOX_W + 1);
  localparam int unsigned RW = $clog2(BOX_H + 1);
  localparam int unsigned TW = $clog2(FRAME_TICKS + 1);
  localparam int unsigned FW = $clog2(FRAMES_PER_STEP + 1);
  localparam logic [X_W:0] XMAX = (X_W + 1)'(SCR_W - BOX_W);
  localparam logic [Y_W:0] YMAX = (Y_W + 1)'(SCR_H - BOX_H);

  typedef enum logic [2:0] {StIdle, StDraw, StWait, StErase, StUpdate} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  col_q;
  logic [RW-1:0]  row_q;
  logic [TW-1:0]  tick_q;
  logic [FW-1:0]  frame_q;
  logic [X_W-1:0] px_q, px_d, ld_x_q, ld_x_c;
  logic [Y_W-1:0] py_q, py_d, ld_y_q, ld_y_c;
  logic           dir_right_q, dir_right_d, dir_down_q, dir_down_d;
  logic           flip_x, flip_y, pend_q;
  logic [2:0]     colour_q, colour_out_q;
  logic [X_W-1:0] x_out_q;
  logic [Y_W-1:0] y_out_q;
  logic           plot_q, bounce_x_q, bounce_y_q;
  logic [X_W:0]   sx, x_sum;
  logic [Y_W:0]   sy, y_sum;
  logic           scan_last, tick_last, frame_last;

  assign scan_last  = (col_q == CW'(BOX_W - 1)) && (row_q == RW'(BOX_H - 1));
  assign tick_last  = (tick_q == TW'(FRAME_TICKS - 1));
  assign frame_last = (frame_q == FW'(FRAMES_PER_STEP - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (bus.run) state_d = StDraw;
      StDraw:   if (scan_last) state_d = StWait;
      StWait:   if (!bus.pause && tick_last && frame_last) state_d = StErase;
      StErase:  if (scan_last) state_d = StUpdate;
      StUpdate: state_d = bus.run ? StDraw : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Motion rule; sums are one bit wider than the coordinates so they cannot wrap.
  always_comb begin
    sx          = (X_W + 1)'(bus.speed_x);
    sy          = (Y_W + 1)'(bus.speed_y);
    x_sum       = {1'b0, px_q} + sx;
    y_sum       = {1'b0, py_q} + sy;
    px_d        = px_q;
    py_d        = py_q;
    dir_right_d = dir_right_q;
    dir_down_d  = dir_down_q;
    flip_x      = 1'b0;
    flip_y      = 1'b0;
    if (sx != '0) begin
      if (dir_right_q) begin
        if (x_sum >= XMAX) begin
          px_d = XMAX[X_W-1:0]; dir_right_d = 1'b0; flip_x = 1'b1;
        end else begin
          px_d = x_sum[X_W-1:0];
        end
      end else if ({1'b0, px_q} <= sx) begin
        px_d = '0; dir_right_d = 1'b1; flip_x = 1'b1;
      end else begin
        px_d = px_q - sx[X_W-1:0];
      end
    end
    if (sy != '0) begin
      if (dir_down_q) begin
        if (y_sum >= YMAX) begin
          py_d = YMAX[Y_W-1:0]; dir_down_d = 1'b0; flip_y = 1'b1;
        end else begin
          py_d = y_sum[Y_W-1:0];
        end
      end else if ({1'b0, py_q} <= sy) begin
        py_d = '0; dir_down_d = 1'b1; flip_y = 1'b1;
      end else begin
        py_d = py_q - sy[Y_W-1:0];
      end
    end
  end

  assign ld_x_c = ({1'b0, bus.load_x} > XMAX) ? XMAX[X_W-1:0] : bus.load_x;
  assign ld_y_c = ({1'b0, bus.load_y} > YMAX) ? YMAX[Y_W-1:0] : bus.load_y;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      tick_q       <= '0;
      frame_q      <= '0;
      px_q         <= XMAX[X_W-1:0];
      py_q         <= '0;
      dir_right_q  <= 1'b0;
      dir_down_q   <= 1'b1;
      pend_q       <= 1'b0;
      ld_x_q       <= '0;
      ld_y_q       <= '0;
      colour_q     <= '0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      colour_out_q <= '0;
      plot_q       <= 1'b0;
      bounce_x_q   <= 1'b0;
      bounce_y_q   <= 1'b0;
    end else begin
      plot_q     <= 1'b0;
      bounce_x_q <= 1'b0;
      bounce_y_q <= 1'b0;
      case (state_q)
        StIdle: if (bus.run) colour_q <= bus.colour_in;
        StDraw, StErase: begin
          plot_q       <= 1'b1;
          x_out_q      <= px_q + X_W'(col_q);
          y_out_q      <= py_q + Y_W'(row_q);
          colour_out_q <= (state_q == StDraw) ? colour_q : 3'd0;
          if (col_q == CW'(BOX_W - 1)) begin
            col_q <= '0;
            row_q <= scan_last ? '0 : row_q + RW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
          if (scan_last) begin
            tick_q  <= '0;
            frame_q <= '0;
          end
        end
        StWait: if (!bus.pause) begin
          if (tick_last) begin
            tick_q  <= '0;
            frame_q <= frame_last ? '0 : frame_q + FW'(1);
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        StUpdate: begin
          if (pend_q) begin
            px_q   <= ld_x_q;
            py_q   <= ld_y_q;
            pend_q <= 1'b0;
          end else begin
            px_q        <= px_d;
            py_q        <= py_d;
            dir_right_q <= dir_right_d;
            dir_down_q  <= dir_down_d;
            bounce_x_q  <= flip_x;
            bounce_y_q  <= flip_y;
          end
          if (bus.run) colour_q <= bus.colour_in;
        end
        default: ;
      endcase
      // Placed after UPDATE so a coincident pulse survives for the next step.
      if (bus.load) begin
        pend_q <= 1'b1;
        ld_x_q <= ld_x_c;
        ld_y_q <= ld_y_c;
      end
    end
  end

  assign bus.x_out      = x_out_q;
  assign bus.y_out      = y_out_q;
  assign bus.colour_out = colour_out_q;
  assign bus.plot       = plot_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.dir_right  = dir_right_q;
  assign bus.dir_down   = dir_down_q;
  assign bus.bounce_x   = bounce_x_q;
  assign bus.bounce_y   = bounce_y_q;
endmodule

// File: tb/tb_box_bouncer.sv
// Bench for box_bouncer: scripted step table, randomized steps against a
// positional model, then run-drop and mid-draw reset sequences.
module tb_box_bouncer;
  localparam int SW = 16, SH = 12, BW = 3, BH = 2, FT = 4, FPS = 2;
  localparam int XMAX = SW - BW, YMAX = SH - BH;

  typedef struct {
    int ex, ey, ecol;          // where and in which colour this step draws
    int sx, sy, ld, lx, ly;    // inputs consumed at this step's update
    int pz, ncol;              // pause length in wait, colour for next step
    int ebx, eby, edr, edd;    // expected result of the update
    int drop;                  // drop run during this step's draw
  } step_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0, n_err = 0;

  box_bouncer_if #(.X_W(8), .Y_W(7)) bus ();

  box_bouncer #(
    .SCR_W(SW), .SCR_H(SH), .BOX_W(BW), .BOX_H(BH), .X_W(8), .Y_W(7),
    .FRAME_TICKS(FT), .FRAMES_PER_STEP(FPS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void axis(input int pos, input int spd, input int dir, input int lim,
                               output int npos, output int ndir, output int flip);
    npos = pos; ndir = dir; flip = 0;
    if (spd == 0) return;
    if (dir != 0) begin
      if (pos + spd >= lim) begin npos = lim; ndir = 0; flip = 1; end
      else npos = pos + spd;
    end else begin
      if (pos <= spd) begin npos = 0; ndir = 1; flip = 1; end
      else npos = pos - spd;
    end
  endfunction

  // Observes one full step, starting at or before its first drawn pixel.
  task automatic do_step(input step_t s);
    int t, lows;
    t = 0;
    while (!bus.plot && t < 200) begin @(negedge clk); t++; end
    check("draw_start", int'(bus.plot), 1);
    for (int k = 0; k < BW * BH; k++) begin
      if (k == 0) check("bounce_one_cycle", int'(bus.bounce_x | bus.bounce_y), 0);
      if (k == 2 && s.drop != 0) bus.run = 1'b0;
      check("draw_plot", int'(bus.plot), 1);
      check("draw_x", int'(bus.x_out), s.ex + k % BW);
      check("draw_y", int'(bus.y_out), s.ey + k / BW);
      check("draw_colour", int'(bus.colour_out), s.ecol);
      @(negedge clk);
    end
    bus.speed_x   = 3'(s.sx);
    bus.speed_y   = 3'(s.sy);
    bus.colour_in = 3'(s.ncol);
    bus.load_x    = 8'(s.lx);
    bus.load_y    = 7'(s.ly);
    lows = 0;
    while (!bus.plot && lows < 200) begin
      bus.load  = (s.ld != 0 && lows == 0);
      bus.pause = (lows >= 2 && lows < 2 + s.pz);
      check("wait_busy", int'(bus.busy), 1);
      @(negedge clk);
      lows++;
    end
    bus.load  = 1'b0;
    bus.pause = 1'b0;
    check("wait_len", lows, FT * FPS + s.pz);
    for (int k = 0; k < BW * BH; k++) begin
      check("erase_plot", int'(bus.plot), 1);
      check("erase_x", int'(bus.x_out), s.ex + k % BW);
      check("erase_y", int'(bus.y_out), s.ey + k / BW);
      check("erase_colour", int'(bus.colour_out), 0);
      @(negedge clk);
    end
    check("gap_plot", int'(bus.plot), 0);
    check("bounce_x", int'(bus.bounce_x), s.ebx);
    check("bounce_y", int'(bus.bounce_y), s.eby);
    check("dir_right", int'(bus.dir_right), s.edr);
    check("dir_down", int'(bus.dir_down), s.edd);
    check("gap_busy", int'(bus.busy), (s.drop != 0) ? 0 : 1);
    @(negedge clk);
  endtask

  step_t tbl[8];

  initial begin
    int mx, my, mdr, mdd, mcol;
    //           ex  ey col sx sy ld  lx  ly pz ncol bx by dr dd drop
    tbl[0] = '{13,  0, 5, 1, 1, 0,  0,  0, 0, 5, 0, 0, 0, 1, 0};
    tbl[1] = '{12,  1, 5, 1, 1, 1,  1,  9, 0, 2, 0, 0, 0, 1, 0};
    tbl[2] = '{ 1,  9, 2, 1, 1, 0,  0,  0, 0, 2, 1, 1, 1, 0, 0};
    tbl[3] = '{ 0, 10, 2, 1, 1, 1, 200, 10, 0, 6, 0, 0, 1, 0, 0};
    tbl[4] = '{13, 10, 6, 1, 0, 0,  0,  0, 0, 6, 1, 0, 0, 0, 0};
    tbl[5] = '{13, 10, 6, 3, 0, 1,  2,  5, 0, 6, 0, 0, 0, 0, 0};
    tbl[6] = '{ 2,  5, 6, 3, 0, 0,  0,  0, 0, 6, 1, 0, 1, 0, 0};
    tbl[7] = '{ 0,  5, 6, 3, 0, 0,  0,  0, 5, 6, 0, 0, 1, 0, 0};

    reset = 1'b1;
    bus.run = 1'b0; bus.pause = 1'b0; bus.colour_in = 3'd5;
    bus.speed_x = 3'd1; bus.speed_y = 3'd1;
    bus.load = 1'b0; bus.load_x = '0; bus.load_y = '0;
    repeat (3) @(negedge clk);
    check("rst_x", int'(bus.x_out), 0);
    check("rst_y", int'(bus.y_out), 0);
    check("rst_colour", int'(bus.colour_out), 0);
    check("rst_plot", int'(bus.plot), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_dir_right", int'(bus.dir_right), 0);
    check("rst_dir_down", int'(bus.dir_down), 1);
    check("rst_bounce", int'(bus.bounce_x | bus.bounce_y), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(bus.busy), 0);
    bus.run = 1'b1;

    for (int i = 0; i < 8; i++) do_step(tbl[i]);

    mx = 3; my = 5; mdr = 1; mdd = 0; mcol = 6;
    for (int i = 0; i < 12; i++) begin
      step_t s;
      int nx, ny, ndr, ndd, fx, fy;
      s.ex = mx; s.ey = my; s.ecol = mcol; s.drop = 0;
      s.sx = int'($urandom_range(0, 7));
      s.sy = int'($urandom_range(0, 7));
      s.ld = ($urandom_range(0, 3) == 0) ? 1 : 0;
      s.lx = int'($urandom_range(0, 255));
      s.ly = int'($urandom_range(0, 127));
      s.pz = int'($urandom_range(0, 3));
      s.ncol = int'($urandom_range(0, 7));
      if (s.ld != 0) begin
        nx = (s.lx > XMAX) ? XMAX : s.lx;
        ny = (s.ly > YMAX) ? YMAX : s.ly;
        ndr = mdr; ndd = mdd; fx = 0; fy = 0;
      end else begin
        axis(mx, s.sx, mdr, XMAX, nx, ndr, fx);
        axis(my, s.sy, mdd, YMAX, ny, ndd, fy);
      end
      s.ebx = fx; s.eby = fy; s.edr = ndr; s.edd = ndd;
      do_step(s);
      mx = nx; my = ny; mdr = ndr; mdd = ndd; mcol = s.ncol;
    end

    // Drop run mid-draw: the step still erases, then the block idles.
    begin
      step_t s;
      int nx, ny, ndr, ndd, fx, fy;
      axis(mx, 1, mdr, XMAX, nx, ndr, fx);
      axis(my, 1, mdd, YMAX, ny, ndd, fy);
      s = '{mx, my, mcol, 1, 1, 0, 0, 0, 0, 4, fx, fy, ndr, ndd, 1};
      do_step(s);
      repeat (4) begin
        check("idle_plot", int'(bus.plot), 0);
        check("idle_busy_low", int'(bus.busy), 0);
        @(negedge clk);
      end
      bus.run = 1'b1;
      s = '{nx, ny, 4, 1, 1, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0};
      s.ebx = -1;
      // Only the draw is observed here; a reset lands partway through it.
      begin
        int t;
        t = 0;
        while (!bus.plot && t < 50) begin @(negedge clk); t++; end
        check("restart_draw_x", int'(bus.x_out), nx);
        check("restart_draw_y", int'(bus.y_out), ny);
        check("restart_colour", int'(bus.colour_out), 4);
        @(negedge clk);
      end
    end

    reset = 1'b1;
    #1;
    check("async_rst_plot", int'(bus.plot), 0);
    check("async_rst_x", int'(bus.x_out), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_dir_down", int'(bus.dir_down), 1);
    bus.colour_in = 3'd3;
    @(negedge clk);
    reset = 1'b0;
    begin
      step_t s;
      s = '{13, 0, 3, 1, 1, 0, 0, 0, 0, 3, 0, 0, 0, 1, 1};
      do_step(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/box_bouncer.md
Name: box_bouncer

Overview:
- Parametrised successor to the fixed 4x4 bouncing-square animator.
- Draws a BOX_W x BOX_H rectangle into the VGA adapter frame buffer, waits a programmable number of frame ticks, erases it, then advances it with per-axis speeds, bouncing off the screen edges.
- Adds run/pause control, runtime speed, asynchronous position load and bounce pulses.
- Sits between the board-level top and vga_adapter; drives its x/y/colour/plot inputs directly.

Parameters:
- SCR_W, 160, screen width in pixels.
- SCR_H, 120, screen height in pixels.
- BOX_W, 4, box width; 1 <= BOX_W < SCR_W.
- BOX_H, 4, box height; 1 <= BOX_H < SCR_H.
- X_W, 8, x coordinate width; 2^X_W >= SCR_W.
- Y_W, 7, y coordinate width; 2^Y_W >= SCR_H.
- FRAME_TICKS, 833333, clk cycles per frame tick (60 Hz at 50 MHz).
- FRAMES_PER_STEP, 15, frame ticks spent in WAIT per step; >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = animate, 0 = finish current step then idle.
- pause  in  1  level; freezes WAIT counters while high.
- colour_in  in  3  box colour; latched on entry to DRAW.
- speed_x  in  3  pixels per step on x, 0..7.
- speed_y  in  3  pixels per step on y, 0..7.
- load  in  1  one-cycle pulse; captures load_x/load_y.
- load_x  in  X_W  requested x.
- load_y  in  Y_W  requested y.
- x_out  out  X_W  pixel x to adapter.
- y_out  out  Y_W  pixel y to adapter.
- colour_out  out  3  pixel colour to adapter.
- plot  out  1  write enable to adapter.
- busy  out  1  high in every state except IDLE.
- dir_right  out  1  current x direction.
- dir_down  out  1  current y direction.
- bounce_x  out  1  one-cycle pulse on an x flip.
- bounce_y  out  1  one-cycle pulse on a y flip.

Behaviour:
- Limits: XMAX = SCR_W-BOX_W, YMAX = SCR_H-BOX_H. Position (px,py) is the top-left corner.
- Reset (async):
  - state IDLE; px = XMAX, py = 0; dir_right = 0, dir_down = 1.
  - All counters 0; load pending cleared.
  - x_out = 0, y_out = 0, colour_out = 0, plot = 0, busy = 0, bounce_x/bounce_y = 0.
- IDLE: run=1 -> DRAW, else stay.
- DRAW:
  - Scans BOX_W*BOX_H pixels, one per cycle, raster order, column counter fastest.
  - Then -> WAIT.
- WAIT:
  - Tick counter counts 0..FRAME_TICKS-1; frame counter increments on wrap.
  - Leaves after FRAMES_PER_STEP frames -> ERASE.
  - Both counters cleared on entry.
  - While pause=1 both counters hold, so the wait is extended by exactly the paused cycles.
- ERASE: same scan as DRAW with colour 0 -> UPDATE.
- UPDATE (1 cycle):
  - Applies the pending load or the motion rule below.
  - Then -> DRAW if run=1, else IDLE.
- Output timing: x_out/y_out/colour_out/plot are registered, valid one cycle after the scan counter value. plot is high exactly BOX_W*BOX_H cycles per DRAW and per ERASE, and 0 otherwise.
- Step period with pause low: 2*BOX_W*BOX_H + FRAME_TICKS*FRAMES_PER_STEP + 1 cycles.
- Motion, x axis (y identical with dir_down/YMAX):
  - Moving right: if px+speed_x >= XMAX then px = XMAX, dir_right = 0, bounce_x = 1; else px += speed_x.
  - Moving left: if px <= speed_x then px = 0, dir_right = 1, bounce_x = 1; else px -= speed_x.
  - speed 0: no movement and no flip.
  - Arithmetic uses X_W+1 bits so it cannot wrap.
- Simultaneous x and y flips (corner) pulse both bounce outputs in the same cycle.
- Load:
  - A load pulse in any state captures min(load_x,XMAX) and min(load_y,YMAX) and sets pending.
  - A later pulse overwrites the captured values.
  - At UPDATE, pending replaces the motion for that step: position set, directions unchanged, no bounce, pending cleared.
  - A load pulse in the same cycle as UPDATE is held for the next UPDATE.
- run falling mid-step: the step completes through ERASE/UPDATE, so the box is never left drawn in IDLE.
- speed_x/speed_y are sampled at UPDATE only.

Test Plan:
- SCR_W=16, SCR_H=12, BOX_W=3, BOX_H=2, FRAME_TICKS=4, FRAMES_PER_STEP=2 used throughout; XMAX=13, YMAX=10.
- Reset, then run=1, speed 1/1, colour_in=5:
  - Plots (13,0),(14,0),(15,0),(13,1),(14,1),(15,1) with colour 5.
  - 8 cycles with plot=0.
  - The same 6 pixels with colour 0.
  - Next DRAW at (12,1); period 21 cycles.
- load (1,9) after reset, speed 1/1 -> next UPDATE sets (1,9). Following UPDATE gives (0,10), dir_right=1, dir_down=0, bounce_x and bounce_y high the same single cycle.
- load (2,5), speed_x=3, dir left -> x=0 with bounce_x; next step x=3. load_x=200 -> px=13.
- pause high for 5 cycles during WAIT -> period 26 cycles, no extra plot pulses, position unchanged by the pause.
- speed_y=0 with py=10 -> py stays 10, no bounce_y. run dropped mid-DRAW -> ERASE completes, then IDLE with busy=0.
- Assert reset during DRAW -> plot=0, x_out=0 and state IDLE immediately (before the next clk edge), px=13, py=0.
